// File: rtl/uart_pkg.sv
// Shared widths and FSM state types for the UART stream bridge.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int RX_ENTRY_W  = UART_BYTE_W + 1;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_ISSUE   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_CLR  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output and an exact level count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [WIDTH-1:0] rdata_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: pop only when non-empty, push when a slot exists or is freed this cycle.
  always_comb begin
    do_pop_s  = pop && (level_r != LVL_W'(0));
    do_push_s = push && ((level_r != LVL_W'(DEPTH)) || do_pop_s);
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  // Pointers, level and the registered head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      rdata_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
      // The head register must already hold the next entry when the level becomes non-zero.
      if (do_pop_s && (level_r != LVL_W'(1))) begin
        rdata_r <= mem_r[rd_ptr_r + AW'(1)];
      end else if (do_push_s && ((level_r == LVL_W'(0)) || do_pop_s)) begin
        rdata_r <= wdata;
      end
    end
  end

  assign rdata = rdata_r;
  assign level = level_r;
endmodule

// File: rtl/uart_stream_bridge.sv
// Valid/ready byte-stream adapter around the UART wr_en/busy and rdy/rdy_clr handshakes.
// Optional macro UART_BRIDGE_DROP_PERR_EN: discard received bytes flagged with a parity error.
module uart_stream_bridge
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BYTE_W-1:0] s_tx_data,
  input  logic                   s_tx_valid,
  output logic                   s_tx_ready,
  output logic [UART_BYTE_W-1:0] m_rx_data,
  output logic                   m_rx_perr,
  output logic                   m_rx_valid,
  input  logic                   m_rx_ready,
  output logic [UART_BYTE_W-1:0] uart_tx_data,
  output logic                   uart_tx_wr_en,
  input  logic                   uart_tx_busy,
  input  logic [UART_BYTE_W-1:0] uart_rx_data,
  input  logic                   uart_rx_rdy,
  input  logic                   uart_rx_perr,
  output logic                   uart_rx_rdy_clr,
  output logic [LVL_W-1:0]       tx_level,
  output logic [LVL_W-1:0]       rx_level,
  output logic                   rx_overflow,
  input  logic                   overflow_clr
);
  tx_state_t              tx_state_r;
  rx_state_t              rx_state_r;
  logic [UART_BYTE_W-1:0] tx_head_s;
  logic [RX_ENTRY_W-1:0]  rx_head_s;
  logic [RX_ENTRY_W-1:0]  rx_cap_r;
  logic                   rx_keep_r;
  logic                   tx_push_s, tx_pop_s;
  logic                   rx_push_s, rx_pop_s, rx_full_s, rx_ovf_set_s;

  assign s_tx_ready = (tx_level != LVL_W'(FIFO_DEPTH));
  assign m_rx_valid = (rx_level != LVL_W'(0));

  // Queue handshakes; an RX capture into a full queue survives only if the consumer pops that cycle.
  always_comb begin
    tx_push_s    = s_tx_valid && s_tx_ready;
    tx_pop_s     = (tx_state_r == TX_IDLE) && (tx_level != LVL_W'(0)) && !uart_tx_busy;
    rx_pop_s     = m_rx_valid && m_rx_ready;
    rx_full_s    = (rx_level == LVL_W'(FIFO_DEPTH));
    rx_push_s    = (rx_state_r == RX_CLR) && rx_keep_r && (!rx_full_s || rx_pop_s);
    rx_ovf_set_s = (rx_state_r == RX_CLR) && rx_keep_r && rx_full_s && !rx_pop_s;
  end

  sync_fifo #(.WIDTH(UART_BYTE_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push_s), .wdata(s_tx_data),
    .pop(tx_pop_s), .rdata(tx_head_s), .level(tx_level)
  );

  sync_fifo #(.WIDTH(RX_ENTRY_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_s), .wdata(rx_cap_r),
    .pop(rx_pop_s), .rdata(rx_head_s), .level(rx_level)
  );

  // TX pacing FSM: issue one byte, then wait for a full busy high/low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r    <= TX_IDLE;
      uart_tx_wr_en <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      uart_tx_wr_en <= 1'b0;
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_pop_s) begin
            uart_tx_data  <= tx_head_s;
            uart_tx_wr_en <= 1'b1;
            tx_state_r    <= TX_ISSUE;
          end
        end
        TX_ISSUE:   tx_state_r <= TX_WAIT_HI;
        TX_WAIT_HI: if (uart_tx_busy) tx_state_r <= TX_WAIT_LO;
        TX_WAIT_LO: if (!uart_tx_busy) tx_state_r <= TX_IDLE;
        default:    tx_state_r <= TX_IDLE;
      endcase
    end
  end

  // RX drain FSM: capture once per rdy assertion, pulse the clear, wait for rdy to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r      <= RX_IDLE;
      uart_rx_rdy_clr <= 1'b0;
      rx_cap_r        <= '0;
      rx_keep_r       <= 1'b0;
      rx_overflow     <= 1'b0;
    end else begin
      uart_rx_rdy_clr <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (uart_rx_rdy) begin
            rx_cap_r        <= {uart_rx_perr, uart_rx_data};
`ifdef UART_BRIDGE_DROP_PERR_EN
            rx_keep_r       <= !uart_rx_perr;
`else
            rx_keep_r       <= 1'b1;
`endif
            uart_rx_rdy_clr <= 1'b1;
            rx_state_r      <= RX_CLR;
          end
        end
        RX_CLR:  rx_state_r <= RX_WAIT;
        RX_WAIT: if (!uart_rx_rdy) rx_state_r <= RX_IDLE;
        default: rx_state_r <= RX_IDLE;
      endcase
      if (rx_ovf_set_s) begin
        rx_overflow <= 1'b1;
      end else if (overflow_clr) begin
        rx_overflow <= 1'b0;
      end
    end
  end

  assign m_rx_data = rx_head_s[UART_BYTE_W-1:0];
`ifdef UART_BRIDGE_DROP_PERR_EN
  assign m_rx_perr = 1'b0;
`else
  assign m_rx_perr = rx_head_s[UART_BYTE_W];
`endif
endmodule

// File: tb/tb_uart_stream_bridge.sv
// Self-checking bench for uart_stream_bridge: directed table, multi-cycle corner cases, random traffic.
module tb_uart_stream_bridge;
`ifdef UART_BRIDGE_DROP_PERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] s_tx_data = 8'h00;
  logic s_tx_valid = 1'b0;
  logic s_tx_ready;
  logic [7:0] m_rx_data;
  logic m_rx_perr, m_rx_valid;
  logic m_rx_ready = 1'b0;
  logic [7:0] uart_tx_data;
  logic uart_tx_wr_en, uart_tx_busy;
  logic [7:0] uart_rx_data = 8'h00;
  logic uart_rx_rdy = 1'b0;
  logic uart_rx_perr = 1'b0;
  logic uart_rx_rdy_clr;
  logic [LW-1:0] tx_level, rx_level;
  logic rx_overflow;
  logic overflow_clr = 1'b0;

  logic busy_m = 1'b0;
  logic busy_hold = 1'b0;
  int   busy_cnt = 0;
  assign uart_tx_busy = busy_m | busy_hold;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int clr_count = 0;
  logic [7:0] tx_seen[$];
  logic [7:0] tx_acc[$];
  logic [8:0] rx_got[$];
  logic [8:0] rx_exp[$];
  bit inj_done;

  uart_stream_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
    .m_rx_data(m_rx_data), .m_rx_perr(m_rx_perr), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_wr_en(uart_tx_wr_en), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_rdy(uart_rx_rdy), .uart_rx_perr(uart_rx_perr),
    .uart_rx_rdy_clr(uart_rx_rdy_clr),
    .tx_level(tx_level), .rx_level(rx_level),
    .rx_overflow(rx_overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 10 cycles after each write strobe; logs every byte sent.
  always @(posedge clk) begin
    if (uart_tx_wr_en) begin
      busy_m   <= 1'b1;
      busy_cnt <= 10;
      tx_seen.push_back(uart_tx_data);
      wr_count <= wr_count + 1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      busy_m   <= 1'b0;
    end
  end

  // Clear-pulse counter and consumer-side pop log.
  always @(posedge clk) begin
    if (uart_rx_rdy_clr) clr_count <= clr_count + 1;
    if (m_rx_valid && m_rx_ready) rx_got.push_back({m_rx_perr, m_rx_data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    int n = 0;
    while (wr_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, wr_count, target);
  endtask

  // Receiver model: present a byte, wait for the clear, keep rdy high 3 cycles past it.
  task automatic inject(input logic [7:0] d, input logic p, input bit pop_at_clr, output int lat);
    lat = 0;
    @(negedge clk);
    uart_rx_rdy = 1'b1; uart_rx_data = d; uart_rx_perr = p;
    do begin
      @(negedge clk);
      lat++;
    end while (!uart_rx_rdy_clr && lat < 20);
    if (lat >= 20) chk("rx_clr_timeout", 32'(uart_rx_rdy_clr), 32'd1);
    if (pop_at_clr) m_rx_ready = 1'b1;
    @(negedge clk);
    m_rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         exp_level;
    logic [7:0] exp_d;
    logic       exp_p;
  } rx_vec_t;

  rx_vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, c0, idx;
    logic [7:0] d;
    logic p;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(uart_tx_wr_en), 32'd0);
    chk("rst_rdy_clr", 32'(uart_rx_rdy_clr), 32'd0);
    chk("rst_rx_valid", 32'(m_rx_valid), 32'd0);
    chk("rst_perr_ovf", {30'd0, m_rx_perr, rx_overflow}, 32'd0);
    chk("rst_data", {16'd0, uart_tx_data, m_rx_data}, 32'd0);
    chk("rst_levels", {24'd0, 3'd0, tx_level[LW-1:0] | rx_level[LW-1:0]}, 32'd0);
    chk("rst_tx_ready", 32'(s_tx_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single byte TX latency and busy pacing
    s_tx_valid = 1'b1; s_tx_data = 8'hA5;
    @(negedge clk);
    s_tx_valid = 1'b0;
    chk("tx_lat_n1_wr_en", 32'(uart_tx_wr_en), 32'd0);
    chk("tx_lat_n1_level", 32'(tx_level), 32'd1);
    @(negedge clk);
    chk("tx_lat_n2_wr_en", 32'(uart_tx_wr_en), 32'd1);
    chk("tx_lat_n2_data", 32'(uart_tx_data), 32'hA5);
    s_tx_valid = 1'b1; s_tx_data = 8'hB6;
    @(negedge clk);
    s_tx_valid = 1'b0;
    chk("tx_wr_en_one_cycle", 32'(uart_tx_wr_en), 32'd0);
    repeat (7) @(negedge clk);
    chk("tx_no_issue_while_busy", 32'(wr_count), 32'd1);
    chk("tx_data_held", 32'(uart_tx_data), 32'hA5);
    wait_wr(2, 40, "tx_second_issue");
    chk("tx_second_data", 32'(tx_seen[1]), 32'hB6);
    repeat (15) @(negedge clk);

    // Fill the TX queue to DEPTH while the UART is held busy, then drain in order
    busy_hold = 1'b1;
    base = wr_count;
    for (int i = 0; i < DEPTH; i++) begin
      s_tx_valid = 1'b1; s_tx_data = 8'(i);
      @(negedge clk);
    end
    s_tx_valid = 1'b0;
    chk("tx_full_level", 32'(tx_level), 32'(DEPTH));
    chk("tx_full_ready", 32'(s_tx_ready), 32'd0);
    busy_hold = 1'b0;
    wait_wr(base + DEPTH, 600, "tx_fill_drain_count");
    for (int i = 0; i < DEPTH; i++) begin
      if (base + i < tx_seen.size()) chk("tx_fill_order", 32'(tx_seen[base + i]), 32'(i));
    end
    chk("tx_level_empty", 32'(tx_level), 32'd0);
    repeat (15) @(negedge clk);

    // RX table: single injections with a 3-cycle rdy tail
    vecs[0] = '{8'h3C, 1'b0, 1, 8'h3C, 1'b0};
    vecs[1] = '{8'h5A, 1'b1, DROP ? 0 : 1, 8'h5A, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 1, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b1, DROP ? 0 : 1, 8'h00, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 1, 8'h81, 1'b0};
    for (int v = 0; v < 5; v++) begin
      c0 = clr_count;
      inject(vecs[v].d, vecs[v].p, 1'b0, lat);
      chk("rx_clr_latency", 32'(lat), 32'd1);
      chk("rx_one_clear", 32'(clr_count - c0), 32'd1);
      chk("rx_level", 32'(rx_level), 32'(vecs[v].exp_level));
      if (vecs[v].exp_level == 1) begin
        chk("rx_data", 32'(m_rx_data), 32'(vecs[v].exp_d));
        chk("rx_perr", 32'(m_rx_perr), 32'(vecs[v].exp_p));
        m_rx_ready = 1'b1;
        @(negedge clk);
        m_rx_ready = 1'b0;
        chk("rx_level_after_pop", 32'(rx_level), 32'd0);
      end
    end

    // RX overflow: fill, drop 77, clear the flag, then push through a same-cycle pop
    for (int i = 0; i < DEPTH; i++) inject(8'(i), 1'b0, 1'b0, lat);
    chk("rx_full_level", 32'(rx_level), 32'(DEPTH));
    chk("rx_full_no_ovf", 32'(rx_overflow), 32'd0);
    c0 = clr_count;
    inject(8'h77, 1'b0, 1'b0, lat);
    chk("ovf_clear_pulsed", 32'(clr_count - c0), 32'd1);
    chk("ovf_level", 32'(rx_level), 32'(DEPTH));
    chk("ovf_flag", 32'(rx_overflow), 32'd1);
    chk("ovf_head", 32'(m_rx_data), 32'h00);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(rx_overflow), 32'd0);
    inject(8'h88, 1'b0, 1'b1, lat);
    chk("full_push_pop_level", 32'(rx_level), 32'(DEPTH));
    chk("full_push_pop_ovf", 32'(rx_overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("rx_drain_valid", 32'(m_rx_valid), 32'd1);
      chk("rx_drain_data", 32'(m_rx_data), (i < DEPTH - 1) ? 32'(i + 1) : 32'h88);
      m_rx_ready = 1'b1;
      @(negedge clk);
      m_rx_ready = 1'b0;
    end
    chk("rx_drained", 32'(rx_level), 32'd0);

    // Reset while waiting for busy to fall with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      s_tx_valid = 1'b1; s_tx_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    s_tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_level", 32'(tx_level), 32'd3);
    base = wr_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_levels", {16'd0, 8'(tx_level), 8'(rx_level)}, 32'd0);
    chk("mid_rst_outs", {28'd0, uart_tx_wr_en, uart_rx_rdy_clr, m_rx_valid, rx_overflow}, 32'd0);
    chk("mid_rst_data", 32'(uart_tx_data), 32'd0);
    repeat (30) @(negedge clk);
    chk("mid_rst_no_wr_en", 32'(wr_count), 32'(base));

    // Randomized concurrent TX and RX traffic against queue-level expectations
    rx_got.delete();
    tx_acc.delete();
    base = wr_count;
    idx  = tx_seen.size();
    inj_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int n;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          n = 0;
          while (!s_tx_ready && n < 500) begin
            @(negedge clk);
            n++;
          end
          s_tx_valid = 1'b1; s_tx_data = 8'($urandom);
          tx_acc.push_back(s_tx_data);
          @(negedge clk);
          s_tx_valid = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          int l2;
          repeat ($urandom_range(0, 4)) @(negedge clk);
          d = 8'($urandom);
          p = 1'($urandom_range(0, 1));
          if (!(DROP && p)) rx_exp.push_back({DROP ? 1'b0 : p, d});
          inject(d, p, 1'b0, l2);
        end
        inj_done = 1'b1;
      end
      begin
        int n = 0;
        while (!(inj_done && rx_level == LW'(0)) && n < 3000) begin
          @(negedge clk);
          m_rx_ready = 1'($urandom_range(0, 1));
          n++;
        end
        m_rx_ready = 1'b0;
        chk("rand_rx_drain_bound", 32'(n < 3000), 32'd1);
      end
    join
    @(negedge clk);
    chk("rand_rx_count", 32'(rx_got.size()), 32'(rx_exp.size()));
    for (int i = 0; i < rx_exp.size(); i++) begin
      if (i < rx_got.size()) chk("rand_rx_entry", 32'(rx_got[i]), 32'(rx_exp[i]));
    end
    chk("rand_rx_no_ovf", 32'(rx_overflow), 32'd0);
    wait_wr(base + 20, 1000, "rand_tx_count");
    for (int i = 0; i < 20; i++) begin
      if (idx + i < tx_seen.size()) chk("rand_tx_order", 32'(tx_seen[idx + i]), 32'(tx_acc[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_stream_bridge.md
# uart_stream_bridge

Buffered byte-stream adapter on the user side of `uart_top`. It accepts bytes on a valid/ready stream, queues them, and paces them into the UART transmitter through its `wr_en`/`busy` handshake. Received bytes are drained from the receiver's `rdy`/`rdy_clr` handshake into a queue and presented on a second valid/ready stream with a per-byte parity flag. The block replaces direct `tx_wr_en`/`rx_rdy_clr` handling in user logic.

## Interface
- `FIFO_DEPTH`, 16: entries per queue; power of two, ≥ 2.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`: width of the level outputs; derived, not overridden.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `s_tx_data`  in  8  byte to transmit
- `s_tx_valid`  in  1  `s_tx_data` valid
- `s_tx_ready`  out  1  TX queue can accept
- `m_rx_data`  out  8  received byte
- `m_rx_perr`  out  1  parity error flag for `m_rx_data`
- `m_rx_valid`  out  1  RX queue non-empty
- `m_rx_ready`  in  1  consumer accepts
- `uart_tx_data`  out  8  to `tx_data_in`
- `uart_tx_wr_en`  out  1  to `tx_wr_en`; one-cycle pulse
- `uart_tx_busy`  in  1  from `tx_busy_out`
- `uart_rx_data`  in  8  from `rx_data_out`
- `uart_rx_rdy`  in  1  from `rx_rdy_out`
- `uart_rx_perr`  in  1  from `rx_parity_error`
- `uart_rx_rdy_clr`  out  1  to `rx_rdy_clr`; one-cycle pulse
- `tx_level`  out  LVL_W  TX queue occupancy
- `rx_level`  out  LVL_W  RX queue occupancy
- `rx_overflow`  out  1  sticky: a byte was lost
- `overflow_clr`  in  1  clears `rx_overflow`

## Operation
- TX queue: push on `s_tx_valid && s_tx_ready`; `s_tx_ready = (tx_level != FIFO_DEPTH)`.
- TX FSM states:
  - TX_IDLE: if the queue is non-empty and `!uart_tx_busy`, pop the head into `uart_tx_data` and go to TX_ISSUE.
  - TX_ISSUE: `uart_tx_wr_en=1` for exactly this cycle → TX_WAIT_HI.
  - TX_WAIT_HI: wait for `uart_tx_busy=1` → TX_WAIT_LO.
  - TX_WAIT_LO: wait for `uart_tx_busy=0` → TX_IDLE.
- `uart_tx_data` holds its value from TX_ISSUE until the next pop.
- RX FSM states:
  - RX_IDLE: on `uart_rx_rdy=1`, push `{uart_rx_perr, uart_rx_data}` into the RX queue and → RX_CLR.
  - RX_CLR: `uart_rx_rdy_clr=1` for one cycle → RX_WAIT.
  - RX_WAIT: wait for `uart_rx_rdy=0` → RX_IDLE. No byte is captured twice.
- RX queue full at capture: a push is accepted if a same-cycle `m_rx_valid && m_rx_ready` pop frees a slot. Otherwise the byte is dropped, `rx_overflow` is set, and the clear pulse is still issued.
- `rx_overflow`: set has priority over `overflow_clr` in the same cycle.
- Simultaneous push and pop on either queue: level unchanged; FIFO ordering preserved.
- Levels are exact counts, 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `uart_tx_wr_en`, `uart_rx_rdy_clr`, `m_rx_valid`, `m_rx_perr`, `rx_overflow`: 0.
  - `uart_tx_data`, `m_rx_data`: 8'h00.
  - Levels: 0, so `s_tx_ready=1`.
  - Both FSMs in IDLE; queue contents are discarded.
- Reset mid-frame abandons the in-flight byte. The bridge does not wait for `uart_tx_busy` to fall.
- TX latency, idle bridge and idle UART: push accepted at cycle N → pop and TX_ISSUE entered at N+1 → `uart_tx_wr_en` high at N+2.
- RX latency: `uart_rx_rdy` sampled high at N → queue write and `uart_rx_rdy_clr` high at N+1 → `m_rx_valid` high at N+2.
- `m_rx_data`/`m_rx_perr` are stable while `m_rx_valid && !m_rx_ready`.
- All outputs are registered except `s_tx_ready` and `m_rx_valid`, which decode registered levels.

## Configuration
- `UART_BRIDGE_DROP_PERR_EN` defined:
  - Bytes with `uart_rx_perr=1` are not queued; `uart_rx_rdy_clr` is still pulsed.
  - `m_rx_perr` is tied 0.
- Undefined:
  - All bytes are queued with their parity flag.
  - `m_rx_perr` reflects the stored flag.

## Structure
- `uart_pkg`: `UART_BYTE_W=8`, `tx_state_t` {TX_IDLE, TX_ISSUE, TX_WAIT_HI, TX_WAIT_LO}, `rx_state_t` {RX_IDLE, RX_CLR, RX_WAIT}.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; outputs registered read data and a level count). Instantiated twice: TX width 8, RX width 9.

## Test plan
- Push 8'hA5 into an idle bridge (busy model: high 10 cycles after `wr_en`) → `uart_tx_wr_en` pulses once at N+2 with `uart_tx_data=8'hA5`; the next byte issues only after busy falls.
- Push 16 bytes 8'h00..8'h0F with `FIFO_DEPTH=16` → `s_tx_ready=0` at level 16; UART sees bytes in order 00..0F; `tx_level` returns to 0.
- Receiver model asserts `rdy` with 8'h3C, holds it 3 cycles after the clear → exactly one clear pulse, one entry, `m_rx_data=8'h3C`.
- With the RX queue full and `m_rx_ready=0`, inject 8'h77 → no push, `rx_overflow=1`, clear pulsed; `overflow_clr` drops the flag next cycle.
- Inject 8'h5A with `perr=1` → undefined macro: `m_rx_perr=1`, data 5A; defined macro: `rx_level` stays 0.
- Assert `rst` during TX_WAIT_LO with 3 bytes queued → next cycle levels are 0, all outputs at reset values, and no `wr_en` fires.
